// File: rtl/masked_rmw_mem.sv
// Single-port memory with byte-masked read-modify-write swaps.
// S1 reads the array (with S2 forwarding); S2 merges, commits and returns the old word.
module masked_rmw_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_write,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_data,
  input  logic [MASK_W-1:0] io_req_mask,
  output logic              io_resp_valid,
  output logic [DATA_W-1:0] io_resp_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              s2_valid_q, s2_valid_d;
  logic              s2_write_q, s2_write_d;
  logic              s2_in_range_q, s2_in_range_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [MASK_W-1:0] s2_mask_q, s2_mask_d;
  logic [DATA_W-1:0] s2_old_q, s2_old_d;

  logic              accept;
  logic              req_in_range;
  logic              commit;
  logic              forward;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] s1_old;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      byte_mask[8*i +: 8] = {8{s2_mask_q[i]}};
    end
  end

  assign merged = (s2_old_q & ~byte_mask) | (s2_data_q & byte_mask);

  // A write held in S2 while reset is high must never reach the array.
  assign commit = s2_valid_q && s2_write_q && s2_in_range_q && (|s2_mask_q) && !reset;

  assign accept       = io_req_valid && !reset;
  assign req_in_range = {1'b0, io_req_addr} < DEPTH_LIM;
  assign forward      = commit && (s2_addr_q == io_req_addr);

  always_comb begin
    s1_old = '0;
    if (req_in_range) begin
      s1_old = forward ? merged : mem_q[io_req_addr[IDX_W-1:0]];
    end
  end

  always_comb begin
    s2_valid_d    = accept;
    s2_write_d    = s2_write_q;
    s2_in_range_d = s2_in_range_q;
    s2_addr_d     = s2_addr_q;
    s2_data_d     = s2_data_q;
    s2_mask_d     = s2_mask_q;
    s2_old_d      = s2_old_q;
    if (accept) begin
      s2_write_d    = io_req_write;
      s2_in_range_d = req_in_range;
      s2_addr_d     = io_req_addr;
      s2_data_d     = io_req_data;
      s2_mask_d     = io_req_mask;
      s2_old_d      = s1_old;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q    <= 1'b0;
      s2_write_q    <= 1'b0;
      s2_in_range_q <= 1'b0;
      s2_addr_q     <= '0;
      s2_data_q     <= '0;
      s2_mask_q     <= '0;
      s2_old_q      <= '0;
    end else begin
      s2_valid_q    <= s2_valid_d;
      s2_write_q    <= s2_write_d;
      s2_in_range_q <= s2_in_range_d;
      s2_addr_q     <= s2_addr_d;
      s2_data_q     <= s2_data_d;
      s2_mask_q     <= s2_mask_d;
      s2_old_q      <= s2_old_d;
    end
  end

  // Array contents survive reset; only the commit port is gated.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[s2_addr_q[IDX_W-1:0]] <= merged;
    end
  end

  assign io_req_ready  = !reset;
  assign io_resp_valid = s2_valid_q && !reset;
  assign io_resp_data  = reset ? '0 : s2_old_q;

endmodule

// File: tb/tb_masked_rmw_mem.sv
// Self-checking bench: directed table on a 32-bit/6-word instance plus a
// random stream on a 64-bit/13-word instance, both scored through response queues.
module tb_masked_rmw_mem;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Directed instance: DATA_W=32, DEPTH=6, ADDR_W=3
  logic        s_valid, s_ready, s_write, s_resp_valid;
  logic [2:0]  s_addr;
  logic [31:0] s_data, s_resp_data;
  logic [3:0]  s_mask;

  // Random instance: DATA_W=64, DEPTH=13, ADDR_W=4
  logic        r_valid, r_ready, r_write, r_resp_valid;
  logic [3:0]  r_addr;
  logic [63:0] r_data, r_resp_data;
  logic [7:0]  r_mask;

  masked_rmw_mem #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .MASK_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .io_req_valid(s_valid), .io_req_ready(s_ready), .io_req_write(s_write),
    .io_req_addr(s_addr), .io_req_data(s_data), .io_req_mask(s_mask),
    .io_resp_valid(s_resp_valid), .io_resp_data(s_resp_data)
  );

  masked_rmw_mem #(.DATA_W(64), .DEPTH(13), .ADDR_W(4), .MASK_W(8)) dut_r (
    .clk(clk), .reset(reset),
    .io_req_valid(r_valid), .io_req_ready(r_ready), .io_req_write(r_write),
    .io_req_addr(r_addr), .io_req_data(r_data), .io_req_mask(r_mask),
    .io_resp_valid(r_resp_valid), .io_resp_data(r_resp_data)
  );

  typedef struct {
    bit          valid;
    bit          write;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    bit          chk;
    int          tag;
  } exp_t;

  vec_t tbl[$];
  exp_t s_q[$];
  exp_t r_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model_mem [13];

  function automatic vec_t mk(bit v, bit w, int a, logic [31:0] d, int m, logic [31:0] e, bit c);
    vec_t t;
    t.valid = v;
    t.write = w;
    t.addr  = 3'(a);
    t.data  = d;
    t.mask  = 4'(m);
    t.exp   = e;
    t.chk   = c;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    s_valid = v.valid;
    s_write = v.write;
    s_addr  = v.addr;
    s_data  = v.data;
    s_mask  = v.mask;
    if (v.valid) begin
      e.exp = 64'(v.exp);
      e.chk = v.chk;
      e.tag = tag;
      s_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (s_resp_valid) begin
      if (s_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL s_unexpected_resp: got data 0x%0h, expected no response", s_resp_data);
      end else begin
        e = s_q.pop_front();
        if (e.chk) checkOutput($sformatf("s_resp[%0d]", e.tag), 64'(s_resp_data), e.exp);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (r_resp_valid) begin
      if (r_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL r_unexpected_resp: got data 0x%0h, expected no response", r_resp_data);
      end else begin
        e = r_q.pop_front();
        if (e.chk) checkOutput($sformatf("r_resp[%0d]", e.tag), r_resp_data, e.exp);
      end
    end
  end

  // Reference model: sequential byte-wise swap, old word returned.
  task automatic modelAccess(input bit w, input int a, input logic [63:0] d, input logic [7:0] m,
                             output logic [63:0] old);
    old = '0;
    if (a < 13) begin
      old = model_mem[a];
      if (w) begin
        for (int b = 0; b < 8; b++) begin
          if (m[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] old;
    int          a;
    int          sel;

    reset   = 1'b1;
    s_valid = 1'b1; s_write = 1'b1; s_addr = 3'd1; s_data = 32'hFFFF_FFFF; s_mask = 4'hF;
    r_valid = 1'b1; r_write = 1'b0; r_addr = 4'd0; r_data = '0;           r_mask = 8'h00;

    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_ready", 64'(s_ready), 64'd0);
      checkOutput("reset_resp_valid", 64'(s_resp_valid), 64'd0);
      checkOutput("reset_resp_data", 64'(s_resp_data), 64'd0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    r_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(s_ready), 64'd1);

    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, i, 32'h1000_0000 + i, 4'hF, 32'h0, 0));
    tbl.push_back(mk(1, 1, 3, 32'hDEAD_BEEF, 4'hF, 32'h1000_0003, 1));
    tbl.push_back(mk(1, 1, 3, 32'h0000_CAFE, 4'h3, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk(1, 0, 3, 32'h0,         4'h0, 32'hDEAD_CAFE, 1));
    tbl.push_back(mk(1, 1, 5, 32'h0,         4'hF, 32'h1000_0005, 1));
    tbl.push_back(mk(1, 1, 5, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1));
    tbl.push_back(mk(1, 1, 5, 32'h0000_BB00, 4'h2, 32'h0000_00AA, 1));
    tbl.push_back(mk(1, 1, 5, 32'h00CC_0000, 4'h4, 32'h0000_BBAA, 1));
    tbl.push_back(mk(1, 0, 5, 32'h0,         4'h0, 32'h00CC_BBAA, 1));
    tbl.push_back(mk(1, 1, 2, 32'h1234_5678, 4'hF, 32'h1000_0002, 1));
    tbl.push_back(mk(1, 1, 2, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 1));
    tbl.push_back(mk(0, 1, 2, 32'hFFFF_FFFF, 4'hF, 32'h0,         0));
    tbl.push_back(mk(1, 0, 2, 32'h0,         4'h0, 32'h1234_5678, 1));
    tbl.push_back(mk(1, 1, 4, 32'h1122_3344, 4'hF, 32'h1000_0004, 1));
    tbl.push_back(mk(1, 1, 4, 32'h0000_00AA, 4'h1, 32'h1122_3344, 1));
    tbl.push_back(mk(1, 0, 4, 32'h0,         4'h0, 32'h1122_33AA, 1));
    tbl.push_back(mk(1, 1, 7, 32'hFFFF_FFFF, 4'hF, 32'h0,         1));
    tbl.push_back(mk(1, 0, 7, 32'h0,         4'h0, 32'h0,         1));
    tbl.push_back(mk(1, 1, 6, 32'h5555_5555, 4'hF, 32'h0,         1));
    tbl.push_back(mk(1, 1, 0, 32'hA0A0_A0A0, 4'hF, 32'h1000_0000, 1));
    tbl.push_back(mk(1, 0, 1, 32'h0,         4'h0, 32'h1000_0001, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,         4'h0, 32'hA0A0_A0A0, 1));
    tbl.push_back(mk(1, 0, 1, 32'h0,         4'h0, 32'h1000_0001, 1));
    tbl.push_back(mk(1, 0, 2, 32'h0,         4'h0, 32'h1234_5678, 1));
    tbl.push_back(mk(1, 0, 3, 32'h0,         4'h0, 32'hDEAD_CAFE, 1));
    tbl.push_back(mk(1, 0, 4, 32'h0,         4'h0, 32'h1122_33AA, 1));
    tbl.push_back(mk(1, 0, 5, 32'h0,         4'h0, 32'h00CC_BBAA, 1));

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_resp_valid", 64'(s_resp_valid), 64'd0);
    checkOutput("idle_resp_hold", 64'(s_resp_data), 64'h00CC_BBAA);

    // Write in flight when reset rises must not reach the array.
    @(posedge clk);
    #1;
    s_valid = 1'b1; s_write = 1'b1; s_addr = 3'd1; s_data = 32'hBAD0_BAD0; s_mask = 4'hF;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("inflight_ready", 64'(s_ready), 64'd0);
    checkOutput("inflight_resp_valid", 64'(s_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(1, 0, 1, 32'h0, 4'h0, 32'h1000_0001, 1), 100);
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      r_valid = 1'b1; r_write = 1'b1; r_addr = 4'(i);
      r_data  = {$urandom, $urandom};
      r_mask  = 8'hFF;
      model_mem[i] = r_data;
      e.exp = '0; e.chk = 1'b0; e.tag = -1;
      r_q.push_back(e);
    end

    for (int n = 0; n < 10000; n++) begin
      @(posedge clk);
      #1;
      r_valid = ($urandom_range(0, 9) != 0);
      r_write = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
      r_addr = 4'(a);
      r_data = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      r_mask = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      if (r_valid) begin
        modelAccess(r_write, a, r_data, r_mask, old);
        e.exp = old; e.chk = 1'b1; e.tag = n;
        r_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    r_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("s_queue_drained", 64'(s_q.size()), 64'd0);
    checkOutput("r_queue_drained", 64'(r_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
